// File: rtl/ser_video_multi.sv
// Multi-lane serial video transmitter: loads one pixel per CLK_6MB rising edge and
// shifts each colour channel out on its own lane, with a latch strobe and overrun flag.
//
// state | meaning
// IDLE  | disabled or no pixel since reset; lanes and strobe held low
// SHIFT | serialising the current word, BIT_CNT = bit index on the lanes
// HOLD  | word complete, waiting for the next pixel load
module ser_video_multi #(
   parameter int DEPTH     = 7,
   parameter int CHANNELS  = 3,
   parameter int LSB_FIRST = 0,
   parameter int LAT_WIDTH = 2
) (
   input  logic                      CLK_SERVID,
   input  logic                      nRESET,
   input  logic                      CLK_6MB,
   input  logic [CHANNELS*DEPTH-1:0] VIDEO_IN,
   input  logic                      BLANK,
   input  logic                      ENABLE,
   input  logic                      ERR_CLR,
   output logic [CHANNELS-1:0]       VIDEO_SER,
   output logic                      VIDEO_CLK_SER,
   output logic                      VIDEO_LAT_SER,
   output logic                      ERR_OVR
);

   localparam int CW       = $clog2(DEPTH);
   localparam int END_BIT  = (LSB_FIRST != 0) ? 0 : DEPTH - 1;
   localparam int NEXT_BIT = (LSB_FIRST != 0) ? 1 : DEPTH - 2;
   localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);
   localparam logic [CW-1:0] LAT_LAST = CW'(LAT_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t              state;
   logic                s0, s1, s2;
   logic                load;
   logic                err_set;
   logic [CW-1:0]       bit_cnt;
   logic [DEPTH-1:0]    sreg [CHANNELS];
   logic [CHANNELS-1:0] first_bits;
   logic [CHANNELS-1:0] next_bits;

   assign VIDEO_CLK_SER = CLK_SERVID;
   assign load          = s1 & ~s2;
   assign err_set       = load & ENABLE & (state == SHIFT) & (bit_cnt < LAST_CNT);

   // Lane values one edge ahead: the word's first bit at load, the following bit while shifting.
   always_comb begin
      first_bits = '0;
      next_bits  = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         first_bits[k] = VIDEO_IN[k*DEPTH + END_BIT] & ~BLANK;
         next_bits[k]  = sreg[k][NEXT_BIT];
      end
   end

   always_ff @(negedge CLK_SERVID or negedge nRESET) begin
      if (!nRESET) begin
         s0            <= 1'b0;
         s1            <= 1'b0;
         s2            <= 1'b0;
         state         <= IDLE;
         bit_cnt       <= '0;
         for (int k = 0; k < CHANNELS; k++) sreg[k] <= '0;
         VIDEO_SER     <= '0;
         VIDEO_LAT_SER <= 1'b0;
         ERR_OVR       <= 1'b0;
      end else begin
         s0      <= CLK_6MB;
         s1      <= s0;
         s2      <= s1;
         ERR_OVR <= err_set | (ERR_OVR & ~ERR_CLR);
         if (!ENABLE) begin
            state         <= IDLE;
            VIDEO_SER     <= '0;
            VIDEO_LAT_SER <= 1'b0;
         end else if (load) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            for (int k = 0; k < CHANNELS; k++)
               sreg[k] <= BLANK ? '0 : VIDEO_IN[k*DEPTH +: DEPTH];
            VIDEO_SER     <= first_bits;
            VIDEO_LAT_SER <= 1'b1;
         end else if (state == SHIFT) begin
            if (bit_cnt == LAST_CNT) begin
               state         <= HOLD;
               VIDEO_SER     <= '0;
               VIDEO_LAT_SER <= 1'b0;
            end else begin
               bit_cnt <= bit_cnt + CW'(1);
               for (int k = 0; k < CHANNELS; k++)
                  sreg[k] <= (LSB_FIRST != 0) ? (sreg[k] >> 1) : (sreg[k] << 1);
               VIDEO_SER     <= next_bits;
               VIDEO_LAT_SER <= (bit_cnt < LAT_LAST);
            end
         end else begin
            VIDEO_SER     <= '0;
            VIDEO_LAT_SER <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ser_video_multi.sv
// Bench for ser_video_multi: two parameterisations driven together and compared each bit clock
// against a word/bit-index reference model, plus directed literal sequences.
module tb_ser_video_multi;

   logic        clk = 1'b0;
   logic        nrst, clk6, blank, en, erc;
   logic [20:0] vin0;
   logic [7:0]  vin1;
   logic [2:0]  ser0;
   logic [1:0]  ser1;
   logic        cks0, cks1, lat0, lat1, err0, err1;

   int n_pass  = 0;
   int n_total = 0;
   int pix_per = 0;
   int pix_ph  = 0;
   int w;
   int lat_cnt;
   logic [2:0] ser_or;
   logic [7:0] sq0, sq1, sq2, sl, sb0, sb1;

   // reference model: last three CLK_6MB samples, then per instance the word and bit index
   logic [2:0]  h;
   int          md   [2] = '{7, 4};
   int          mch  [2] = '{3, 2};
   int          mlsb [2] = '{0, 1};
   int          mlat [2] = '{2, 1};
   logic        m_act  [2];
   int          m_idx  [2];
   logic        m_err  [2];
   logic [31:0] m_word [2];

   always #5 clk = ~clk;

   ser_video_multi u_a (
      .CLK_SERVID(clk), .nRESET(nrst), .CLK_6MB(clk6), .VIDEO_IN(vin0), .BLANK(blank),
      .ENABLE(en), .ERR_CLR(erc), .VIDEO_SER(ser0), .VIDEO_CLK_SER(cks0),
      .VIDEO_LAT_SER(lat0), .ERR_OVR(err0));

   ser_video_multi #(.DEPTH(4), .CHANNELS(2), .LSB_FIRST(1), .LAT_WIDTH(1)) u_b (
      .CLK_SERVID(clk), .nRESET(nrst), .CLK_6MB(clk6), .VIDEO_IN(vin1), .BLANK(blank),
      .ENABLE(en), .ERR_CLR(erc), .VIDEO_SER(ser1), .VIDEO_CLK_SER(cks1),
      .VIDEO_LAT_SER(lat1), .ERR_OVR(err1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   function automatic logic [7:0] exp_ser(input int m);
      logic [7:0] r;
      int pos;
      r = '0;
      if (m_act[m]) begin
         pos = (mlsb[m] != 0) ? m_idx[m] : md[m] - 1 - m_idx[m];
         for (int k = 0; k < mch[m]; k++) r[k] = m_word[m][k*md[m] + pos];
      end
      return r;
   endfunction

   task automatic model_reset();
      h = '0;
      for (int m = 0; m < 2; m++) begin
         m_act[m] = 1'b0;
         m_idx[m] = 0;
         m_err[m] = 1'b0;
      end
   endtask

   task automatic model_step();
      logic ld, set;
      ld = h[1] & ~h[2];
      h  = {h[1:0], clk6};
      for (int m = 0; m < 2; m++) begin
         set = 1'b0;
         if (!en) begin
            m_act[m] = 1'b0;
         end else if (ld) begin
            if (m_act[m] && m_idx[m] < md[m] - 1) set = 1'b1;
            m_word[m] = blank ? 32'd0 : ((m == 0) ? {11'd0, vin0} : {24'd0, vin1});
            m_idx[m]  = 0;
            m_act[m]  = 1'b1;
         end else if (m_act[m]) begin
            if (m_idx[m] == md[m] - 1) m_act[m] = 1'b0;
            else m_idx[m]++;
         end
         if (set) m_err[m] = 1'b1;
         else if (erc) m_err[m] = 1'b0;
      end
   endtask

   task automatic check_all();
      logic [7:0] e0, e1;
      e0 = exp_ser(0);
      e1 = exp_ser(1);
      chk("ser_a", {29'd0, ser0}, {29'd0, e0[2:0]});
      chk("lat_a", {31'd0, lat0}, (m_act[0] && m_idx[0] < mlat[0]) ? 32'd1 : 32'd0);
      chk("err_a", {31'd0, err0}, {31'd0, m_err[0]});
      chk("ser_b", {30'd0, ser1}, {30'd0, e1[1:0]});
      chk("lat_b", {31'd0, lat1}, (m_act[1] && m_idx[1] < mlat[1]) ? 32'd1 : 32'd0);
      chk("err_b", {31'd0, err1}, {31'd0, m_err[1]});
   endtask

   // drive CLK_6MB for the coming falling edge, predict it, then check half a cycle later
   task automatic tick();
      if (pix_per > 0) begin
         pix_ph = (pix_ph + 1) % pix_per;
         clk6   = (pix_ph < pix_per / 2);
      end else begin
         clk6 = 1'b0;
      end
      if (!nrst) model_reset();
      else model_step();
      @(posedge clk);
      check_all();
   endtask

   initial begin
      nrst = 1'b1; clk6 = 1'b0; blank = 1'b0; en = 1'b1; erc = 1'b0;
      vin0 = '0; vin1 = '0;
      model_reset();
      #1 nrst = 1'b0;
      @(posedge clk); #1;
      chk("rst_ser_a", {29'd0, ser0}, 32'd0);
      chk("rst_lat_a", {31'd0, lat0}, 32'd0);
      chk("rst_err_a", {31'd0, err0}, 32'd0);
      chk("rst_ser_b", {30'd0, ser1}, 32'd0);
      chk("clk_copy_hi", {31'd0, cks0}, 32'd1);
      @(negedge clk); #1;
      chk("clk_copy_lo", {31'd0, cks1}, 32'd0);
      @(posedge clk);
      tick();
      tick();

      // known pixel: 0x55 / 0x7F / 0x00 MSB-first, and 0001 / 0110 LSB-first on DEPTH=4
      vin0 = {7'h00, 7'h7F, 7'h55};
      vin1 = {4'b0110, 4'b0001};
      pix_per = 8; pix_ph = 7;
      nrst = 1'b1;
      w = 0;
      while (w < 20 && lat0 !== 1'b1) begin tick(); w++; end
      chk("wait_first_lat", (w < 20) ? 32'd1 : 32'd0, 32'd1);
      sq0 = '0; sq1 = '0; sq2 = '0; sl = '0; sb0 = '0; sb1 = '0;
      for (int i = 0; i < 8; i++) begin
         sq0 = {sq0[6:0], ser0[0]};
         sq1 = {sq1[6:0], ser0[1]};
         sq2 = {sq2[6:0], ser0[2]};
         sl  = {sl[6:0], lat0};
         if (i < 4) begin
            sb0 = {sb0[6:0], ser1[0]};
            sb1 = {sb1[6:0], ser1[1]};
         end
         tick();
      end
      chk("seq_ch0", {24'd0, sq0}, 32'b10101010);
      chk("seq_ch1", {24'd0, sq1}, 32'b11111110);
      chk("seq_ch2", {24'd0, sq2}, 32'd0);
      chk("seq_lat", {24'd0, sl},  32'b11000000);
      chk("lsb_ch0", {24'd0, sb0}, 32'b1000);
      chk("lsb_ch1", {24'd0, sb1}, 32'b0110);
      chk("no_err_normal", {31'd0, err0}, 32'd0);

      // blanked pixel: lanes stay low while the strobe still fires
      blank = 1'b1; vin0 = '1; vin1 = '1;
      for (int i = 0; i < 7; i++) tick();
      ser_or = '0; lat_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         ser_or  = ser_or | ser0;
         lat_cnt = lat_cnt + int'(lat0);
      end
      chk("blank_ser", {29'd0, ser_or}, 32'd0);
      chk("blank_lat_cnt", lat_cnt, 32'd2);
      blank = 1'b0;

      // pixel clock every 4 bit clocks: DEPTH=7 overruns, DEPTH=4 lands exactly on its last bit
      pix_per = 4;
      for (int i = 0; i < 24; i++) begin
         vin0 = 21'($urandom);
         vin1 = 8'($urandom);
         tick();
      end
      chk("overrun_err_a", {31'd0, err0}, 32'd1);
      chk("no_overrun_b", {31'd0, err1}, 32'd0);
      w = 0;
      while (w < 8 && !(h[1] & ~h[2])) begin tick(); w++; end
      erc = 1'b1;
      tick();
      erc = 1'b0;
      chk("set_beats_clr", {31'd0, err0}, 32'd1);
      pix_per = 0;
      for (int i = 0; i < 3; i++) tick();
      erc = 1'b1;
      tick();
      erc = 1'b0;
      chk("err_cleared", {31'd0, err0}, 32'd0);

      // asynchronous reset in the middle of a word
      vin0 = '1; vin1 = '1;
      pix_per = 8;
      w = 0;
      while (w < 30 && !(m_act[0] && m_idx[0] == 3)) begin tick(); w++; end
      chk("wait_bitcnt3", (w < 30) ? 32'd1 : 32'd0, 32'd1);
      nrst = 1'b0;
      #1;
      chk("async_rst_ser_a", {29'd0, ser0}, 32'd0);
      chk("async_rst_ser_b", {30'd0, ser1}, 32'd0);
      chk("async_rst_lat", {31'd0, lat0}, 32'd0);
      tick();
      tick();
      vin0 = {7'h00, 7'h7F, 7'h55};
      nrst = 1'b1;
      w = 0;
      while (w < 20 && lat0 !== 1'b1) begin tick(); w++; end
      chk("wait_lat_after_rst", (w < 20) ? 32'd1 : 32'd0, 32'd1);
      chk("resume_first_bit", {29'd0, ser0}, 32'b011);

      // ENABLE dropped mid-word, then restored
      w = 0;
      while (w < 30 && !(m_act[0] && m_idx[0] == 2)) begin tick(); w++; end
      chk("wait_bitcnt2", (w < 30) ? 32'd1 : 32'd0, 32'd1);
      en = 1'b0;
      tick();
      chk("en_drop_ser", {29'd0, ser0}, 32'd0);
      chk("en_drop_lat", {31'd0, lat0}, 32'd0);
      for (int i = 0; i < 5; i++) tick();
      en = 1'b1;
      w = 0;
      while (w < 20 && lat0 !== 1'b1) begin tick(); w++; end
      chk("wait_lat_after_en", (w < 20) ? 32'd1 : 32'd0, 32'd1);
      chk("en_restore_first_bit", {29'd0, ser0}, 32'b011);

      // randomized traffic at assorted pixel rates
      for (int p = 0; p < 8; p++) begin
         pix_per = $urandom_range(3, 14);
         for (int i = 0; i < 40; i++) begin
            vin0  = 21'($urandom);
            vin1  = 8'($urandom);
            blank = ($urandom_range(0, 7) == 0);
            en    = ($urandom_range(0, 15) != 0);
            erc   = ($urandom_range(0, 15) == 0);
            tick();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
